pp_final_adder: RTL
===================

# pp_final_adder

Pipelined carry-propagate adder that sits directly downstream of the 16x16 multiplier's Wallace-tree partial-product compressor. It takes the compressor's two redundant vectors and sums them, with correct carry alignment, into the final 32-bit product. It adds a valid/ready handshake so the multiplier datapath can stall under downstream backpressure without losing or duplicating results.

## Interface
Parameters:
- none; widths are fixed by the 16x16 multiplier.

Ports:
- clk  input  1  sole clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  `ppout1`/`ppout2` hold a valid compressed pair.
- in_ready  output  1  block accepts the pair this cycle.
- ppout1  input  32  compressor sum vector; bit k has weight 2^k.
- ppout2  input  30  compressor carry vector; bit k has weight 2^(k+2).
- product  output  32  final product, held stable while `out_valid && !out_ready`.
- out_valid  output  1  `product` is valid.
- out_ready  input  1  consumer accepts `product` this cycle.
- busy  output  1  at least one pipeline stage holds a valid entry.

## Operation
- Result is `product = (ppout1 + {ppout2, 2'b00}) mod 2^32`.
  - The carry out of bit 31 is discarded.
  - The compressor's sign encoding relies on this wrap to produce the two's-complement product.
- A transfer occurs on a cycle where `in_valid && in_ready`. The same rule applies at the output (`out_valid && out_ready`).
- Two-stage mode (macro defined):
  - S1 registers `low = ppout1[15:0] + {ppout2[13:0],2'b00}` as 17 bits (16-bit sum plus carry). It also registers `ppout1[31:16]` and `ppout2[29:14]` unchanged.
  - S2 computes `high = ppout1_hi + ppout2_hi + low[16]` modulo 2^16 and registers `product = {high, low[15:0]}`.
- Single-stage mode (macro undefined): the full 32-bit sum is registered directly into the output stage.
- Each stage has a valid bit `vN` and is a plain pipeline register with backpressure.
  - Stage N loads when it is empty or its contents are leaving this cycle.
  - The output stage's ready is `out_ready`. An earlier stage's ready is `!v(N+1) || ready(N+1)`.
  - `in_ready` is the first stage's ready.
  - `in_ready` combinationally depends on `out_ready`; no skid buffer is used.
- `busy = |vN`.
- There is no state machine beyond the per-stage valid bits. The sequencing is fully described by the load/hold rule above.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert): all `vN` = 0, `product` = 0, `out_valid` = 0, `busy` = 0.
  - `in_ready` = 1 as soon as reset is released.
  - Data registers may also reset to 0; `product` must read 0 during reset.
- Latency: 2 cycles from the input transfer to `out_valid` in two-stage mode, 1 cycle in single-stage mode.
- Throughput: one result per cycle while `out_ready` = 1.
- Full pipeline with `out_ready` = 0: `in_ready` = 0 and `product` stays stable. No entry is overwritten or dropped.
- Simultaneous events:
  - Output consumed and input accepted in the same cycle: both happen; the pipeline stays full with no bubble.
  - A bubble in S1 while S2 is stalled: S1 still accepts a new input.
- `in_valid` deasserting mid-stream leaves a bubble. Bubbles never raise `out_valid`.
- Reset asserted mid-operation: all in-flight results are discarded immediately and `out_valid` drops asynchronously.
- `ppout1`/`ppout2` are sampled only on an input transfer; their value at any other time is ignored.

## Configuration
- `PP_FINAL_ADDER_SPLIT_EN`
  - Defined: two-stage split adder as described, latency 2. The 16-bit critical path suits the higher-frequency target.
  - Undefined: single 32-bit adder stage, latency 1. The handshake and reset behaviour are otherwise identical.
- Product values must match bit-for-bit in both builds.

## Test plan
- Reset release, then `ppout1` = 0x0000_0001, `ppout2` = 0x3FFF_FFFF, `in_valid` = 1 for one cycle, `out_ready` = 1 -> `product` = 0xFFFF_FFFD with `out_valid` high for exactly one cycle, after 2 cycles (split build) or 1 cycle (unsplit build).
- Carry across the half boundary: `ppout1` = 0x0000_FFFF, `ppout2` = 0x0000_0001 -> `product` = 0x0001_0003.
- Back-to-back stream of 4 pairs with `out_ready` held 0 -> `in_ready` falls after 2 accepts (split build). Raising `out_ready` then delivers all 4 results in order, one per cycle, with no duplicates.
- End to end: drive the compressor outputs for 0x7FFF x 0x8000 and for 0xFFFF x 0xFFFF, with signed Booth inputs, through this block -> `product` = 0xC000_8000 and 0x0000_0001 respectively.
- Random `in_valid` and `out_ready` over 10k cycles against a reference sum -> every accepted pair produces exactly one matching `product`, in order.
- Assert `rst_n` = 0 while 2 entries are in flight -> `out_valid` = 0 and `busy` = 0 immediately. After release, no stale result appears and `in_ready` = 1.

Source files
------------

// File: rtl/pp_final_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pp_final_adder: carry-propagate adder for the 16x16 multiplier's           |
// | compressor outputs, valid/ready pipelined. Build option:                   |
// | PP_FINAL_ADDER_SPLIT_EN selects the two-stage 16/16 split adder.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pp_final_adder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] ppout1,
  input  logic [29:0] ppout2,
  output logic [31:0] product,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy
);

`ifdef PP_FINAL_ADDER_SPLIT_EN
  logic        r_v1;
  logic        r_v2;
  logic [16:0] r_low;
  logic [15:0] r_hi1;
  logic [15:0] r_hi2;
  logic [31:0] r_product;
  logic        w_ld1;
  logic        w_ld2;
  logic [15:0] w_high;

  assign w_ld2  = !r_v2 || out_ready;
  assign w_ld1  = !r_v1 || w_ld2;
  assign w_high = r_hi1 + r_hi2 + {15'd0, r_low[16]};

  // Low half sum keeps its carry for the high half in the next stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1  <= 1'b0;
      r_low <= 17'd0;
      r_hi1 <= 16'd0;
      r_hi2 <= 16'd0;
    end else if (w_ld1) begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_low <= {1'b0, ppout1[15:0]} + {1'b0, ppout2[13:0], 2'b00};
        r_hi1 <= ppout1[31:16];
        r_hi2 <= ppout2[29:14];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2      <= 1'b0;
      r_product <= 32'd0;
    end else if (w_ld2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_product <= {w_high, r_low[15:0]};
      end
    end
  end

  assign in_ready  = w_ld1;
  assign out_valid = r_v2;
  assign busy      = r_v1 | r_v2;
  assign product   = r_product;
`else
  logic        r_v;
  logic [31:0] r_product;
  logic        w_ld;

  assign w_ld = !r_v || out_ready;

  // Carry out of bit 31 is dropped; the compressor's sign encoding needs the wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v       <= 1'b0;
      r_product <= 32'd0;
    end else if (w_ld) begin
      r_v <= in_valid;
      if (in_valid) begin
        r_product <= ppout1 + {ppout2, 2'b00};
      end
    end
  end

  assign in_ready  = w_ld;
  assign out_valid = r_v;
  assign busy      = r_v;
  assign product   = r_product;
`endif

endmodule
`default_nettype wire
